// File: rtl/audio_serial_tx_if.sv
// Sample push bus for audio_serial_tx: a 32-bit word with a valid/ready handshake.
// The producer drives x and x_valid; the transmitter answers with x_ready.
interface audio_serial_tx_if;
  logic [31:0] x;
  logic        x_valid;
  logic        x_ready;

  modport master (output x, output x_valid, input x_ready);
  modport slave  (input x, input x_valid, output x_ready);
endinterface

// File: rtl/audio_serial_tx.sv
// Serial audio transmitter. Samples are queued in a small FIFO and shifted out
// MSB first on sd. Each word is framed by ws (0 = left, 1 = right), and sck is
// derived from c by a BCLK_DIV half-period divider. Data changes only on sck
// falling edges, so the receiver can sample sd on sck rising edges. A missing
// word is replaced by zero and flagged on underrun. When en drops, the current
// left/right frame completes before the block stops.
module audio_serial_tx #(
  parameter int DEPTH    = 4,
  parameter int BCLK_DIV = 4
) (
  input  logic                     c,
  input  logic                     r_n,
  audio_serial_tx_if.slave         smp,
  input  logic                     en,
  output logic                     sck,
  output logic                     ws,
  output logic                     sd,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = $clog2(BCLK_DIV);

  typedef enum logic {IDLE, RUN} state_t;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic [31:0]   head;
  logic          push;
  logic          pop;

  state_t        state;
  state_t        state_next;
  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_next;
  logic [4:0]    bit_cnt;
  logic [4:0]    bit_next;
  logic [31:0]   shreg;
  logic [31:0]   shreg_next;
  logic          sck_q;
  logic          sck_next;
  logic          ws_q;
  logic          ws_next;
  logic          underrun_q;
  logic          underrun_next;

  assign smp.x_ready = (count < LW'(DEPTH));
  assign push        = smp.x_valid && smp.x_ready;
  assign head        = mem[rd_ptr];
  assign level       = count;

  assign sck      = sck_q;
  assign ws       = ws_q;
  assign sd       = shreg[31];
  assign underrun = underrun_q;

  // Sample storage; contents need no reset because the pointers define validity.
  always_ff @(posedge c) begin
    if (push) begin
      mem[wr_ptr] <= smp.x;
    end
  end

  // FIFO pointers and occupancy. A simultaneous push and pop leave the count unchanged.
  always_ff @(posedge c or negedge r_n) begin
    if (!r_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // Transmitter state register: FSM state, divider, bit counter, shifter and serial outputs.
  always_ff @(posedge c or negedge r_n) begin
    if (!r_n) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      sck_q      <= 1'b0;
      ws_q       <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state      <= state_next;
      div_cnt    <= div_next;
      bit_cnt    <= bit_next;
      shreg      <= shreg_next;
      sck_q      <= sck_next;
      ws_q       <= ws_next;
      underrun_q <= underrun_next;
    end
  end

  // Next-state logic. The divider toggles sck on each wrap. All data movement
  // happens on the wrap that takes sck from 1 to 0. The word boundary either
  // reloads from the FIFO (or substitutes zero) or, after the right word with
  // en low, returns to IDLE.
  always_comb begin
    state_next    = state;
    div_next      = div_cnt;
    bit_next      = bit_cnt;
    shreg_next    = shreg;
    sck_next      = sck_q;
    ws_next       = ws_q;
    underrun_next = 1'b0;
    pop           = 1'b0;

    case (state)
      IDLE: begin
        div_next   = '0;
        bit_next   = '0;
        shreg_next = '0;
        sck_next   = 1'b0;
        ws_next    = 1'b0;
        if (en && (count != '0)) begin
          state_next = RUN;
          pop        = 1'b1;
          shreg_next = head;
        end
      end

      RUN: begin
        if (div_cnt == DW'(BCLK_DIV - 1)) begin
          div_next = '0;
          sck_next = ~sck_q;
          if (sck_q) begin
            if (bit_cnt == 5'd31) begin
              bit_next = '0;
              if (ws_q && !en) begin
                state_next = IDLE;
                sck_next   = 1'b0;
                ws_next    = 1'b0;
                shreg_next = '0;
              end else begin
                ws_next = ~ws_q;
                if (count != '0) begin
                  pop        = 1'b1;
                  shreg_next = head;
                end else begin
                  shreg_next    = '0;
                  underrun_next = 1'b1;
                end
              end
            end else begin
              shreg_next = {shreg[30:0], 1'b0};
              bit_next   = bit_cnt + 5'd1;
            end
          end
        end else begin
          div_next = div_cnt + DW'(1);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: doc/audio_serial_tx.md
AUDIO_SERIAL_TX -- requirements
Module: audio_serial_tx

Interface
REQ-001 Parameter DEPTH, default 4; sample FIFO depth in 32-bit words, power of two, at least 2.
REQ-002 Parameter BCLK_DIV, default 4; number of c cycles per half period of sck, at least 2.
REQ-003 Port c  input  1  single system clock; all state updates on posedge c.
REQ-004 Port r_n  input  1  asynchronous, active-low reset.
REQ-005 Port x  input  32  parallel audio sample; channels alternate left then right.
REQ-006 Port x_valid  input  1  x carries a sample this cycle.
REQ-007 Port x_ready  output  1  FIFO can accept a sample this cycle.
REQ-008 Port en  input  1  enables serial transmission.
REQ-009 Port sck  output  1  serial bit clock.
REQ-010 Port ws  output  1  word select; 0 = left, 1 = right.
REQ-011 Port sd  output  1  serial data, MSB first.
REQ-012 Port underrun  output  1  one-cycle pulse when a word is due and the FIFO is empty.
REQ-013 Port level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-014 A sample is pushed on a posedge c where x_valid and x_ready are both high; x_ready = (level < DEPTH), combinational on level only.
REQ-015 When x_valid is high and x_ready is low, the sample is dropped and the FIFO is unchanged.
REQ-016 A push and a pop in the same cycle leave level unchanged; a pop from an empty FIFO never occurs.
REQ-017 The FSM has two states, IDLE and RUN.
REQ-018 In IDLE: sck=0, ws=0, sd=0; the divider counter and bit counter are held at 0.
REQ-019 IDLE -> RUN on the first posedge where en=1 and level>0; on that edge the head word is popped into the shift register, ws=0, and sd takes the word's bit 31 on the same edge.
REQ-020 In RUN, a divider counts 0..BCLK_DIV-1; sck toggles on each wrap, i.e. the first sck rise occurs BCLK_DIV cycles after RUN entry.
REQ-021 The receiver samples sd on the rising edge of sck; sd, ws and the shift register change only on the edge where sck goes 1->0.
REQ-022 On each sck fall, the shift register shifts left by one, sd takes the new bit 31, and the bit counter (0..31) increments.
REQ-023 On the sck fall that completes bit 31, the next word is loaded and ws toggles on the same edge.
REQ-024 If the FIFO is empty when the next word is loaded, 32'h0 is loaded and underrun is asserted for exactly that one c cycle.
REQ-025 A frame is 64 bits, i.e. 128*BCLK_DIV c cycles.
REQ-026 RUN -> IDLE only on the sck fall that completes the right-channel bit 31 with en=0; no word is popped and no underrun is raised on that edge.
REQ-027 Deasserting en mid-frame completes the current left/right frame before stopping.
REQ-028 FIFO pointers wrap modulo DEPTH without loss; level saturates at neither 0 nor DEPTH, because overflow and underflow are prevented by REQ-014 to REQ-016.

Reset
REQ-029 While r_n=0, regardless of c: state=IDLE, FIFO empty (level=0), x_ready=1, sck=0, ws=0, sd=0, underrun=0, all counters at 0.
REQ-030 Reset asserted mid-frame aborts transmission immediately and discards FIFO contents.
REQ-031 After r_n rises, the block behaves exactly as from power-up and waits in IDLE per REQ-019.

Verification (DEPTH=4, BCLK_DIV=2)
REQ-032 Scenario: push 32'hA5A5_0001, 32'h5A5A_0002, then en=1 -> sd carries A5A50001 MSB first with ws=0 over 32 sck rises, then 5A5A0002 with ws=1; sck period = 4 c cycles.
REQ-033 Scenario: push 5 samples back-to-back with en=0 -> x_ready falls after the 4th push, the 5th is dropped, level=4.
REQ-034 Scenario: push 1 sample, en=1 -> after 32 bits, right-channel word = 32'h0, underrun pulses for one cycle, ws=1.
REQ-035 Scenario: en dropped during the left word of frame 2 -> the right word completes, then IDLE, sck=0, ws=0, sd=0, and the remaining FIFO words are retained.
REQ-036 Scenario: r_n pulsed low mid-bit between c edges -> outputs cleared immediately, level=0, x_ready=1.
REQ-037 Scenario: FIFO full (level=4) with x_valid held high during RUN -> each pop re-enables x_ready for one cycle and one push lands in it, level stays 4, and no sample is lost or duplicated.
